clint_timer: RTL and testbench

- Memory-mapped core-local interruptor that sits directly upstream of the CSR file.
- Holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit.
- Drives the `timer_interrupt` and `software_interrupt` inputs of the CSR file.
- Programmed over the core's simple data-bus slave interface: word accesses, one-cycle registered response.

---
 rtl/clint_timer_pkg.sv | 38 +++
 rtl/clint_prescaler.sv | 37 +++
 rtl/clint_timer.sv | 123 ++++++++++++
 tb/tb_clint_timer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/clint_timer_pkg.sv
// Shared offsets, widths and register decode for the core-local interruptor.
package clint_timer_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TIME_W     = 64;
  localparam int unsigned PRESCALE_W = 16;

  localparam logic [ADDR_W-1:0] MSIP_OFF        = 16'h0000;
  localparam logic [ADDR_W-1:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [ADDR_W-1:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [ADDR_W-1:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [ADDR_W-1:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  // Word-address decode; byte lanes addr[1:0] play no part.
  function automatic reg_sel_e decode_reg(input logic [ADDR_W-1:2] word_addr);
    reg_sel_e r;
    r = REG_NONE;
    if (word_addr == MSIP_OFF[ADDR_W-1:2])             r = REG_MSIP;
    else if (word_addr == MTIMECMP_LO_OFF[ADDR_W-1:2]) r = REG_CMP_LO;
    else if (word_addr == MTIMECMP_HI_OFF[ADDR_W-1:2]) r = REG_CMP_HI;
    else if (word_addr == MTIME_LO_OFF[ADDR_W-1:2])    r = REG_TIME_LO;
    else if (word_addr == MTIME_HI_OFF[ADDR_W-1:2])    r = REG_TIME_HI;
    return r;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the clock down to mtime increment ticks; freezes on halt.
module clint_prescaler
  import clint_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic halt_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  assign tick_c_o = ~halt_i & (count_q == LAST);

  // Next count: clear wins, halt holds, otherwise count and wrap at LAST.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (!halt_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-cycle bus slave.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              halt,
  output logic              timer_interrupt,
  output logic              software_interrupt
);

  logic [TIME_W-1:0] mtime_q,    mtime_d;
  logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
  logic              msip_q,     msip_d;
  logic [DATA_W-1:0] shadow_hi_q, shadow_hi_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              ready_q,    ready_d;
  logic              tint_q,     tint_d;
  logic              sint_q,     sint_d;

  logic     wr_c, rd_c, time_wr_c, tick_c;
  reg_sel_e reg_c;
  logic     unused_ok_c;

  // Block only sees its offset; the base address is decoded upstream.
  assign unused_ok_c = ^{addr[1:0], BASE_ADDR};

  assign reg_c     = decode_reg(addr[ADDR_W-1:2]);
  assign wr_c      = sel & wen;
  assign rd_c      = sel & ren & ~wen;
  assign time_wr_c = wr_c & ((reg_c == REG_TIME_LO) | (reg_c == REG_TIME_HI));

  clint_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .halt_i   (halt),
    .clr_i    (time_wr_c),
    .tick_c_o (tick_c)
  );

  // Register writes, mtime increment, read mux and interrupt compares.
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    shadow_hi_d = shadow_hi_q;
    rdata_d     = '0;
    ready_d     = sel & (ren | wen);
    tint_d      = (mtime_q >= mtimecmp_q);
    sint_d      = msip_q;

    if (wr_c) begin
      case (reg_c)
        REG_MSIP:    msip_d              = wdata[0];
        REG_CMP_LO:  mtimecmp_d[31:0]    = wdata;
        REG_CMP_HI:  mtimecmp_d[63:32]   = wdata;
        REG_TIME_LO: mtime_d[31:0]       = wdata;
        REG_TIME_HI: mtime_d[63:32]      = wdata;
        default:     ;
      endcase
    end

    // A software write to mtime swallows a coincident tick.
    if (!time_wr_c && tick_c) begin
      mtime_d = mtime_q + TIME_W'(1);
    end

    if (rd_c) begin
      case (reg_c)
        REG_MSIP:    rdata_d = DATA_W'(msip_q);
        REG_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        REG_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        REG_TIME_LO: begin
          rdata_d     = mtime_q[31:0];
          shadow_hi_d = mtime_q[63:32];
        end
        REG_TIME_HI: rdata_d = shadow_hi_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  // State and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RST;
      msip_q      <= 1'b0;
      shadow_hi_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      tint_q      <= 1'b0;
      sint_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      shadow_hi_q <= shadow_hi_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      tint_q      <= tint_d;
      sint_q      <= sint_d;
    end
  end

  assign rdata              = rdata_q;
  assign ready              = ready_q;
  assign timer_interrupt    = tint_q;
  assign software_interrupt = sint_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one PRESCALE=1 and one PRESCALE=4 instance.
module tb_clint_timer;

  logic        clock;
  logic        reset;
  logic        sel1, sel4;
  logic [15:0] addr;
  logic        ren, wen;
  logic [31:0] wdata;
  logic        halt;
  logic [31:0] rdata1, rdata4;
  logic        ready1, ready4;
  logic        ti1, ti4, si1, si4;

  int checks = 0;
  int errors = 0;

  clint_timer #(.PRESCALE(1)) u_dut1 (
    .clock(clock), .reset(reset), .sel(sel1), .addr(addr), .ren(ren), .wen(wen),
    .wdata(wdata), .rdata(rdata1), .ready(ready1), .halt(halt),
    .timer_interrupt(ti1), .software_interrupt(si1)
  );

  clint_timer #(.PRESCALE(4)) u_dut4 (
    .clock(clock), .reset(reset), .sel(sel4), .addr(addr), .ren(ren), .wen(wen),
    .wdata(wdata), .rdata(rdata4), .ready(ready4), .halt(halt),
    .timer_interrupt(ti4), .software_interrupt(si4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One request cycle on the chosen instance; checks the ready cycle that follows.
  task automatic xfer(input bit d4, input bit r, input bit w, input logic [15:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input string tag);
    sel1 = ~d4; sel4 = d4; ren = r; wen = w; addr = a; wdata = wd;
    cyc(1);
    sel1 = 1'b0; sel4 = 1'b0; ren = 1'b0; wen = 1'b0;
    chk({tag, "_ready"}, 32'(d4 ? ready4 : ready1), 32'd1);
    chk(tag, d4 ? rdata4 : rdata1, exp);
  endtask

  initial begin
    reset = 1'b0; sel1 = 1'b0; sel4 = 1'b0; addr = '0; ren = 1'b0; wen = 1'b0;
    wdata = '0; halt = 1'b0;
    cyc(3);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_ready", 32'(ready1), 32'd0);
    chk("rst_tint", 32'(ti1), 32'd0);
    chk("rst_sint", 32'(si1), 32'd0);
    reset = 1'b1;

    // mtimecmp reset value and single-cycle ready
    xfer(0, 1, 0, 16'h4000, 32'd0, 32'hFFFF_FFFF, "cmp_lo_rst");
    cyc(1);
    chk("ready_one_cycle", 32'(ready1), 32'd0);
    chk("rdata_idle", rdata1, 32'd0);
    xfer(0, 1, 0, 16'h4004, 32'd0, 32'hFFFF_FFFF, "cmp_hi_rst");
    chk("tint_after_rst", 32'(ti1), 32'd0);
    chk("sint_after_rst", 32'(si1), 32'd0);

    // timer interrupt rises 11 cycles after the mtime-write ready cycle
    xfer(0, 0, 1, 16'h4004, 32'd0, 32'd0, "w_cmp_hi");
    xfer(0, 0, 1, 16'h4000, 32'd10, 32'd0, "w_cmp_lo");
    xfer(0, 0, 1, 16'hBFF8, 32'd0, 32'd0, "w_time_lo");
    for (int k = 1; k <= 11; k++) begin
      cyc(1);
      if (k < 11) chk("tint_pre", 32'(ti1), 32'd0);
      else        chk("tint_rise", 32'(ti1), 32'd1);
    end
    cyc(5);
    chk("tint_hold", 32'(ti1), 32'd1);
    xfer(0, 0, 1, 16'h4000, 32'd100, 32'd0, "w_cmp_100");
    chk("tint_lag", 32'(ti1), 32'd1);
    cyc(1);
    chk("tint_fall", 32'(ti1), 32'd0);

    // 32-bit carry and shadowed high-half read
    xfer(0, 0, 1, 16'hBFF8, 32'hFFFF_FFFE, 32'd0, "w_time_lo_fe");
    xfer(0, 0, 1, 16'hBFFC, 32'd0, 32'd0, "w_time_hi_0");
    cyc(2);
    xfer(0, 1, 0, 16'hBFF8, 32'd0, 32'd0, "carry_lo");
    cyc(1);
    xfer(0, 0, 1, 16'hBFFC, 32'd5, 32'd0, "w_time_hi_5");
    xfer(0, 1, 0, 16'hBFFC, 32'd0, 32'd1, "shadow_hi");
    xfer(0, 1, 0, 16'hBFF8, 32'd0, 32'd3, "lo_after_hi_wr");
    xfer(0, 1, 0, 16'hBFFC, 32'd0, 32'd5, "shadow_hi_new");

    // PRESCALE=4: halt freezes, release for 12 cycles gives 3 ticks
    xfer(1, 0, 1, 16'hBFF8, 32'd0, 32'd0, "p4_clr_lo");
    xfer(1, 0, 1, 16'hBFFC, 32'd0, 32'd0, "p4_clr_hi");
    halt = 1'b1;
    cyc(8);
    halt = 1'b0;
    cyc(12);
    xfer(1, 1, 0, 16'hBFF8, 32'd0, 32'd3, "p4_halt_count");
    cyc(2);
    xfer(1, 0, 1, 16'hBFF8, 32'h55, 32'd0, "p4_wr_on_tick");
    xfer(1, 1, 0, 16'hBFF8, 32'd0, 32'h55, "p4_wr_priority");

    // msip and software interrupt timing
    xfer(0, 0, 1, 16'h0000, 32'hFFFF_FFFF, 32'd0, "w_msip_1");
    chk("sint_lag", 32'(si1), 32'd0);
    cyc(1);
    chk("sint_set", 32'(si1), 32'd1);
    xfer(0, 1, 0, 16'h0000, 32'd0, 32'd1, "msip_rd");
    xfer(0, 0, 1, 16'h0000, 32'd0, 32'd0, "w_msip_0");
    chk("sint_hold", 32'(si1), 32'd1);
    cyc(1);
    chk("sint_clr", 32'(si1), 32'd0);
    xfer(0, 1, 1, 16'h0000, 32'd1, 32'd0, "rw_both");
    xfer(0, 1, 0, 16'h0000, 32'd0, 32'd1, "rw_both_wrote");

    // back-to-back reads, then reset mid-transaction
    xfer(0, 0, 1, 16'hBFF8, 32'h1000, 32'd0, "w_known");
    sel1 = 1'b1; ren = 1'b1; addr = 16'h1234;
    cyc(1);
    chk("b2b_ready0", 32'(ready1), 32'd1);
    chk("b2b_unmapped", rdata1, 32'd0);
    addr = 16'hBFF8;
    cyc(1);
    chk("b2b_ready1", 32'(ready1), 32'd1);
    chk("b2b_mtime", rdata1, 32'h1001);
    sel1 = 1'b0; ren = 1'b0;
    cyc(1);
    chk("b2b_idle", 32'(ready1), 32'd0);
    sel1 = 1'b1; ren = 1'b1; addr = 16'hBFF8;
    cyc(1);
    chk("mid_ready_pre", 32'(ready1), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready1), 32'd0);
    chk("mid_rst_rdata", rdata1, 32'd0);
    sel1 = 1'b0; ren = 1'b0;
    cyc(2);
    reset = 1'b1;
    xfer(0, 1, 0, 16'hBFF8, 32'd0, 32'd0, "mid_rst_mtime");
    xfer(0, 1, 0, 16'h4000, 32'd0, 32'hFFFF_FFFF, "mid_rst_cmp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
